// File: rtl/inv_mix_columns_sequencer.sv
// ----------------------------------------------------------------------------
// inv_mix_columns_sequencer
//
// Column-serial InvMixColumns stage for the AES decryption round. A 128-bit
// state is accepted over a valid/ready handshake. COLS_PER_CYCLE column units
// are time-shared across the four state columns. The result is returned over
// a second valid/ready handshake. A bypass path serves the final round, which
// has no InvMixColumns.
//
// Parameters:
//   COLS_PER_CYCLE - columns processed per compute cycle (1, 2 or 4).
//
// Optional build macro:
//   MIX_FWD_EN - adds input fwd_mode. When fwd_mode is set on accept, the
//                forward MixColumns matrix is used instead of the inverse.
//
// Ports:
//   clk        in   clock; everything on the rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   in_data / in_bypass (/ fwd_mode) valid
//   in_ready   out  block can accept a state (IDLE)
//   in_data    in   [0:127] state; byte k = in_data[8k:8k+7]; column c = bytes 4c..4c+3
//   in_bypass  in   1 = pass the state through unmodified
//   fwd_mode   in   (MIX_FWD_EN only) 1 = forward MixColumns matrix
//   out_valid  out  out_data valid (DONE)
//   out_ready  in   downstream accepts out_data
//   out_data   out  [0:127] result, same layout as in_data
//   busy       out  high in COMPUTE or DONE
// ----------------------------------------------------------------------------
module inv_mix_columns_sequencer #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_bypass,
`ifdef MIX_FWD_EN
    input  logic         fwd_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    // Counter value at which the final group of columns is processed.
    localparam int LAST_COL = 4 - COLS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t       state;
    logic [1:0]   col_cnt;
    logic [0:127] work;
`ifdef MIX_FWD_EN
    logic         fwd_sel;
`endif

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_res [COLS_PER_CYCLE];

    // Multiply by 02 in GF(2^8) mod 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse mix of one column; col[31:24] is row 0.
    // Products are built from the 02/04/08 multiples of each byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

`ifdef MIX_FWD_EN
    // Forward mix of one column (matrix 02 03 01 01, rotated per row).
    function automatic logic [31:0] fwd_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m3 [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            m2[r] = xtime(a[r]);
            m3[r] = m2[r] ^ a[r];
        end
        return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
    endfunction
`endif

    // Column units: unit u handles column col_cnt+u. col_cnt is always a
    // multiple of COLS_PER_CYCLE, so the 2-bit sum never wraps mid-group.
    always_comb begin
        for (int u = 0; u < COLS_PER_CYCLE; u++) begin
            col_idx[u] = col_cnt + 2'(u);
`ifdef MIX_FWD_EN
            if (fwd_sel) begin
                col_res[u] = fwd_mix_col(work[32*int'(col_idx[u]) +: 32]);
            end else begin
                col_res[u] = inv_mix_col(work[32*int'(col_idx[u]) +: 32]);
            end
`else
            col_res[u] = inv_mix_col(work[32*int'(col_idx[u]) +: 32]);
`endif
        end
    end

    // Controller with registered handshake outputs. The working register is
    // data only and is not reset; out_data is reset so that no stale result
    // survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            col_cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        col_cnt  <= 2'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef MIX_FWD_EN
                        fwd_sel  <= fwd_mode;
`endif
                        if (in_bypass) begin
                            // Final round: result is the input itself.
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state     <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    for (int u = 0; u < COLS_PER_CYCLE; u++) begin
                        out_data[32*int'(col_idx[u]) +: 32] <= col_res[u];
                    end
                    col_cnt <= col_cnt + 2'(COLS_PER_CYCLE);
                    if (col_cnt == 2'(LAST_COL)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    col_cnt   <= 2'd0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_sequencer.sv
// ----------------------------------------------------------------------------
// tb_inv_mix_columns_sequencer
//
// Three instances (COLS_PER_CYCLE = 1, 2, 4) share one input stream and one
// out_ready. Expected results are pushed to a queue on accept; each instance
// has its own read index into the queue, and an entry is popped once all
// three instances have consumed it. The expectations come from fixed known
// answers or from a generic GF(2^8) shift-and-add matrix model.
// ----------------------------------------------------------------------------
module tb_inv_mix_columns_sequencer;

    typedef logic [0:127] vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    vec_t         in_data = '0;
    logic         in_bypass = 1'b0;
    logic         fwd_mode = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   busy_v;
    vec_t         out_data_v [3];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    vec_t exp_q [$];
    int   rd [3];
    int   acc [3];
    int   exp_lat [3];
    logic prev_valid [3];
    logic prev_hs [3];
    vec_t prev_data [3];
    logic prev_rst = 1'b1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_sequencer #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .in_bypass (in_bypass),
`ifdef MIX_FWD_EN
            .fwd_mode  (fwd_mode),
`endif
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_data  (out_data_v[g]),
            .busy      (busy_v[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference GF(2^8) multiply (shift-and-add, mod 0x11B).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    // Row r of the matrix is the base row rotated right by r.
    function automatic vec_t model(input vec_t d, input logic fwd);
        logic [7:0] inv_row [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [7:0] fwd_row [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0] a [4];
        logic [7:0] o;
        vec_t       res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = d[32*c + 8*r +: 8];
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int j = 0; j < 4; j++)
                    o = o ^ gmul(fwd ? fwd_row[(j - r) & 3] : inv_row[(j - r) & 3], a[j]);
                res[32*c + 8*r +: 8] = o;
            end
        end
        return res;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (!rst && in_valid && in_ready_v[i]) begin
                acc[i]     <= cyc;
                // Bypass registers the result on the accept edge itself, so it
                // is visible in the cycle right after accept.
                exp_lat[i] <= in_bypass ? 0 : (4 >> i);
            end
        end
    end

    // Output monitor: latency, hold-while-stalled, and result on handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && !prev_rst) begin
                if (out_valid_v[i] && !prev_valid[i])
                    check($sformatf("latency_u%0d", i), 128'(cyc - acc[i] - 1), 128'(exp_lat[i]));
                if (prev_valid[i] && !prev_hs[i]) begin
                    check($sformatf("valid_hold_u%0d", i), 128'(out_valid_v[i]), 128'd1);
                    check($sformatf("data_hold_u%0d", i), out_data_v[i], prev_data[i]);
                end
            end
            if (!rst && out_valid_v[i] && out_ready) begin
                if (rd[i] < exp_q.size()) begin
                    check($sformatf("result_u%0d", i), out_data_v[i], exp_q[rd[i]]);
                    rd[i]++;
                end else begin
                    check($sformatf("spurious_u%0d", i), 128'd1, 128'd0);
                end
            end
            prev_valid[i] = out_valid_v[i];
            prev_data[i]  = out_data_v[i];
            prev_hs[i]    = !rst && out_valid_v[i] && out_ready;
        end
        prev_rst = rst;
        while (exp_q.size() > 0 && rd[0] > 0 && rd[1] > 0 && rd[2] > 0) begin
            void'(exp_q.pop_front());
            for (int i = 0; i < 3; i++) rd[i]--;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready_v !== 3'b111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready_v !== 3'b111) check("ready_timeout", 128'(in_ready_v), 128'h7);
    endtask

    task automatic send(input vec_t d, input logic byp, input logic fwd, input vec_t exp);
        wait_ready();
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = byp;
        fwd_mode  = fwd;
        @(posedge clk);
        exp_q.push_back(exp);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(rd[0] == exp_q.size() && rd[1] == exp_q.size() && rd[2] == exp_q.size()) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 128'(exp_q.size() - rd[0]), 128'd0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_in_ready_u%0d", tag, i), 128'(in_ready_v[i]), 128'd1);
            check($sformatf("%s_out_valid_u%0d", tag, i), 128'(out_valid_v[i]), 128'd0);
            check($sformatf("%s_out_data_u%0d", tag, i), out_data_v[i], 128'd0);
            check($sformatf("%s_busy_u%0d", tag, i), 128'(busy_v[i]), 128'd0);
        end
    endtask

    initial begin
        vec_t kat_in, kat_out, v, b;
        int   n;
        kat_in  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
        kat_out = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 0; acc[i] = 0; exp_lat[i] = 0;
            prev_valid[i] = 1'b0; prev_hs[i] = 1'b0; prev_data[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Known answer on all three widths, then a column of equal bytes.
        out_ready = 1'b1;
        send(kat_in, 1'b0, 1'b0, kat_out);
        drain();
        send(128'h01010101_8e4da1bc_01010101_9fdc589d, 1'b0, 1'b0,
             128'h01010101_db135345_01010101_f20a225c);
        drain();

        // Bypass passes the state through.
        send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b0,
             128'h00112233_44556677_8899aabb_ccddeeff);
        drain();

        // Random states, random bypass, back to back.
        for (int k = 0; k < 6; k++) begin
            logic byp;
            v   = {$urandom(), $urandom(), $urandom(), $urandom()};
            byp = ($urandom_range(0, 3) == 0);
            send(v, byp, 1'b0, byp ? v : model(v, 1'b0));
        end
        drain();

        // Back-pressure: results held, a second input is refused until IDLE.
        out_ready = 1'b0;
        send(kat_in, 1'b0, 1'b0, kat_out);
        n = 0;
        while (out_valid_v !== 3'b111 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 128'(out_valid_v), 128'h7);
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid  = 1'b1;
        in_data   = b;
        in_bypass = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready_v), 128'h0);
            check("bp_busy", 128'(busy_v), 128'h7);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_ready", 128'(in_ready_v), 128'h7);
        @(posedge clk);
        exp_q.push_back(model(b, 1'b0));
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 128'(busy_v), 128'h7);
        drain();

        // Reset two cycles after accept, with out_ready high at the same time.
        out_ready = 1'b0;
        send(kat_in, 1'b0, 1'b0, kat_out);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) rd[i] = 0;
        @(negedge clk);
        check_reset_state("midrst");
        send(kat_in, 1'b0, 1'b0, kat_out);
        drain();

`ifdef MIX_FWD_EN
        send(kat_out, 1'b0, 1'b1, kat_in);
        drain();
        send(kat_out, 1'b1, 1'b1, kat_out);
        drain();
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(v, 1'b0, 1'b1, model(v, 1'b1));
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
